// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Merges a data channel and a protocol channel onto one UART transmitter.
//   Each channel has a one-entry holding register. The arbiter picks a full
//   channel, presents {tag, payload} and pulses o_uart_start. It then waits
//   for the transmitter to go busy (i_uart_ready low) and idle again.
//   If the transmitter never drops ready, o_timeout pulses once and the
//   arbiter returns to IDLE.
//
//   Optional feature: UART_TX_ARB_RR_EN
//     defined   -> round-robin between channels when both are full
//     undefined -> data channel has fixed priority when both are full
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous reset, active low
//   i_data_dat     data-channel payload (7 bits)
//   i_data_valid   data-channel byte offered
//   o_data_ready   data-channel holding register empty
//   i_prot_dat     protocol-channel payload (7 bits)
//   i_prot_valid   protocol-channel byte offered
//   o_prot_ready   protocol-channel holding register empty
//   o_uart_dat     {tag, payload} to the transmitter
//   o_uart_start   one-cycle start pulse
//   i_uart_ready   transmitter idle
//   o_grant        channel of the last start (0 data, 1 protocol)
//   o_timeout      one-cycle pulse when the ready-drop wait expires
//
// state     | meaning
// IDLE      | waiting for a full channel and an idle transmitter
// START     | start pulse out, selected holding register freed
// WAIT_LOW  | waiting for the transmitter to go busy (timed)
// WAIT_HIGH | waiting for the transmitter to become idle again

module uart_tx_arbiter #(
   parameter logic        TAG_PROT      = 1'b1,
   parameter int unsigned READY_TIMEOUT = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [6:0] i_data_dat,
   input  logic       i_data_valid,
   output logic       o_data_ready,
   input  logic [6:0] i_prot_dat,
   input  logic       i_prot_valid,
   output logic       o_prot_ready,
   output logic [7:0] o_uart_dat,
   output logic       o_uart_start,
   input  logic       i_uart_ready,
   output logic       o_grant,
   output logic       o_timeout
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(READY_TIMEOUT - 1);

   state_t     state_q;
   state_t     state_d;
   logic       data_full;
   logic       prot_full;
   logic [6:0] data_hold;
   logic [6:0] prot_hold;
   logic [7:0] tmo_cnt;
   logic       pick_prot;
   logic       load_sel;
   logic       tmo_hit;

   assign o_data_ready = ~data_full;
   assign o_prot_ready = ~prot_full;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      load_sel = 1'b0;
      tmo_hit  = 1'b0;
`ifdef UART_TX_ARB_RR_EN
      // both full: the channel that did not go last wins
      pick_prot = prot_full & (~data_full | ~o_grant);
`else
      pick_prot = prot_full & ~data_full;
`endif
      case (state_q)
         IDLE: begin
            if ((data_full || prot_full) && i_uart_ready) begin
               load_sel = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!i_uart_ready) begin
               state_d = WAIT_HIGH;
            end else if (tmo_cnt >= TMO_LAST) begin
               tmo_hit = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_HIGH: begin
            if (i_uart_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         data_full    <= 1'b0;
         prot_full    <= 1'b0;
         data_hold    <= '0;
         prot_hold    <= '0;
         o_uart_dat   <= 8'h00;
         o_uart_start <= 1'b0;
         o_grant      <= 1'b1;
         o_timeout    <= 1'b0;
         tmo_cnt      <= '0;
      end else begin
         // capture needs an empty register, clear needs a full one,
         // so the two can never hit the same channel on one edge
         if (i_data_valid && !data_full) begin
            data_hold <= i_data_dat;
            data_full <= 1'b1;
         end else if (state_q == START && !o_grant) begin
            data_full <= 1'b0;
         end

         if (i_prot_valid && !prot_full) begin
            prot_hold <= i_prot_dat;
            prot_full <= 1'b1;
         end else if (state_q == START && o_grant) begin
            prot_full <= 1'b0;
         end

         if (load_sel) begin
            o_grant    <= pick_prot;
            o_uart_dat <= pick_prot ? {TAG_PROT, prot_hold} : {~TAG_PROT, data_hold};
         end

         o_uart_start <= (state_d == START);
         o_timeout    <= tmo_hit;

         // held at zero outside WAIT_LOW, so it starts from zero on entry
         if (state_q != WAIT_LOW) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Randomized and directed stimulus for uart_tx_arbiter, checked against a
//   behavioural model: per-channel full flag + held payload, the arbitration
//   rule applied to the flags seen before each start, and a transmitter
//   model that drops and raises ready after random delays (or never drops).

module tb_uart_tx_arbiter;

   localparam logic TAG = 1'b1;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [6:0] i_data_dat;
   logic       i_data_valid;
   logic       o_data_ready;
   logic [6:0] i_prot_dat;
   logic       i_prot_valid;
   logic       o_prot_ready;
   logic [7:0] o_uart_dat;
   logic       o_uart_start;
   logic       i_uart_ready;
   logic       o_grant;
   logic       o_timeout;

   always #5 i_clk = ~i_clk;

   uart_tx_arbiter #(
      .TAG_PROT      (TAG),
      .READY_TIMEOUT (16)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_data_dat   (i_data_dat),
      .i_data_valid (i_data_valid),
      .o_data_ready (o_data_ready),
      .i_prot_dat   (i_prot_dat),
      .i_prot_valid (i_prot_valid),
      .o_prot_ready (o_prot_ready),
      .o_uart_dat   (o_uart_dat),
      .o_uart_start (o_uart_start),
      .i_uart_ready (i_uart_ready),
      .o_grant      (o_grant),
      .o_timeout    (o_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   bit         m_df, m_pf;
   logic [6:0] m_dh, m_ph;
   logic [7:0] m_last_dat;
   bit         m_last_gr;
   bit         st_prev, st_ch;
   int         since_start;
   int         tick_no;
   int         last_acc_tick;
   int         n_start, n_tmo;
   bit         order[$];

   // stimulus control
   logic [6:0] q_d[$];
   logic [6:0] q_p[$];
   bit         use_q;
   int         rand_pct;
   bit         chk_lat, chk_b2b;

   // transmitter model
   bit tx_busy, tx_stuck, tx_rdy_m;
   int tx_phase, tx_cnt;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic drive_inputs();
      if (use_q) begin
         i_data_valid = (q_d.size() > 0);
         i_data_dat   = (q_d.size() > 0) ? q_d[0] : 7'h00;
         i_prot_valid = (q_p.size() > 0);
         i_prot_dat   = (q_p.size() > 0) ? q_p[0] : 7'h00;
      end else begin
         i_data_valid = (int'($urandom_range(99)) < rand_pct);
         i_data_dat   = 7'($urandom);
         i_prot_valid = (int'($urandom_range(99)) < rand_pct);
         i_prot_dat   = 7'($urandom);
      end
      i_uart_ready = tx_busy ? 1'b0 : tx_rdy_m;
   endtask

   task automatic tick();
      bit         pre_d, pre_p, acc_d, acc_p, ch, exp_tmo, rst_edge;
      logic [7:0] edat;
      @(posedge i_clk);
      tick_no++;
      pre_d    = m_df;
      pre_p    = m_pf;
      rst_edge = !i_reset;
      if (rst_edge) begin
         m_df = 0; m_pf = 0; m_last_dat = 8'h00; m_last_gr = 1'b1;
         st_prev = 0; since_start = 1000;
      end else begin
         acc_d = i_data_valid && !m_df;
         acc_p = i_prot_valid && !m_pf;
         if (st_prev) begin
            if (st_ch) m_pf = 0;
            else       m_df = 0;
         end
         if (acc_d) begin
            m_df = 1; m_dh = i_data_dat; last_acc_tick = tick_no;
            if (use_q) void'(q_d.pop_front());
         end
         if (acc_p) begin
            m_pf = 1; m_ph = i_prot_dat; last_acc_tick = tick_no;
            if (use_q) void'(q_p.pop_front());
         end
         if (since_start < 1000) since_start++;
      end

      @(negedge i_clk);
      check("data_ready", 32'(o_data_ready), 32'(!m_df));
      check("prot_ready", 32'(o_prot_ready), 32'(!m_pf));
      exp_tmo = tx_stuck && (since_start == 17);
      check("timeout", 32'(o_timeout), 32'(exp_tmo));
      if (o_timeout) n_tmo++;
      if (rst_edge) check("start_in_reset", 32'(o_uart_start), 32'(0));
      if (o_uart_start) begin
         n_start++;
         check("start_pending", 32'(pre_d | pre_p), 32'(1));
         if (pre_d && pre_p) begin
`ifdef UART_TX_ARB_RR_EN
            ch = !m_last_gr;
`else
            ch = 1'b0;
`endif
         end else begin
            ch = pre_p;
         end
         edat = ch ? {TAG, m_ph} : {~TAG, m_dh};
         check("grant", 32'(o_grant), 32'(ch));
         check("uart_dat", 32'(o_uart_dat), 32'(edat));
         if (chk_lat) check("latency", 32'(tick_no - last_acc_tick), 32'(1));
         if (chk_b2b && since_start < 1000) check("restart_gap", 32'(since_start), 32'(18));
         m_last_gr = ch; m_last_dat = edat; st_prev = 1; st_ch = ch; since_start = 0;
         order.push_back(ch);
         if (!tx_stuck) begin
            tx_phase = 1;
            tx_cnt   = int'($urandom_range(4, 2));
         end
      end else begin
         st_prev = 0;
         check("hold_dat", 32'(o_uart_dat), 32'(m_last_dat));
         check("hold_grant", 32'(o_grant), 32'(m_last_gr));
      end

      if (tx_phase == 1) begin
         tx_cnt--;
         if (tx_cnt == 0) begin
            tx_rdy_m = 1'b0; tx_phase = 2; tx_cnt = int'($urandom_range(5, 1));
         end
      end else if (tx_phase == 2) begin
         tx_cnt--;
         if (tx_cnt == 0) begin
            tx_rdy_m = 1'b1; tx_phase = 0;
         end
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      q_d.delete(); q_p.delete(); order.delete();
      n_start = 0; n_tmo = 0; tx_phase = 0; tx_rdy_m = 1'b1;
      i_reset = 1'b0;
      drive_inputs();
      tick();
      tick();
      i_reset = 1'b1;
      drive_inputs();
   endtask

   task automatic wait_starts(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && n_start < target; i++) tick();
      check(tag, 32'(n_start), 32'(target));
   endtask

   initial begin
      int n0;
      bit exp_ch;
      i_reset = 1'b0; use_q = 1; rand_pct = 0; chk_lat = 0; chk_b2b = 0;
      tx_busy = 0; tx_stuck = 0; tx_rdy_m = 1'b1; tx_phase = 0; tx_cnt = 0;
      since_start = 1000; tick_no = 0; last_acc_tick = 0;
      m_df = 0; m_pf = 0; m_dh = '0; m_ph = '0; m_last_dat = 8'h00; m_last_gr = 1'b1;
      st_prev = 0; st_ch = 0; n_start = 0; n_tmo = 0;
      drive_inputs();
      tick();
      check("rst_dat",   32'(o_uart_dat),   32'(8'h00));
      check("rst_start", 32'(o_uart_start), 32'(0));
      check("rst_grant", 32'(o_grant),      32'(1));
      check("rst_tmo",   32'(o_timeout),    32'(0));
      check("rst_rdy_d", 32'(o_data_ready), 32'(1));
      check("rst_rdy_p", 32'(o_prot_ready), 32'(1));

      // single bytes: latency and tagging
      do_reset();
      chk_lat = 1;
      q_d.push_back(7'h41);
      drive_inputs();
      wait_starts(1, 10, "lat_data_start");
      check("data41_dat",   32'(o_uart_dat), 32'(8'h41));
      check("data41_grant", 32'(o_grant),    32'(0));
      repeat (12) tick();
      q_p.push_back(7'h12);
      drive_inputs();
      wait_starts(2, 10, "lat_prot_start");
      check("prot12_dat",   32'(o_uart_dat), 32'(8'h92));
      check("prot12_grant", 32'(o_grant),    32'(1));
      chk_lat = 0;
      repeat (12) tick();

      // both channels loaded, three bytes each
      tx_busy = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         q_d.push_back(7'($urandom));
         q_p.push_back(7'($urandom));
      end
      drive_inputs();
      repeat (5) tick();
      tx_busy = 0;
      drive_inputs();
      wait_starts(6, 200, "order_starts");
      for (int i = 0; i < 6; i++) begin
`ifdef UART_TX_ARB_RR_EN
         exp_ch = (i % 2) == 1;
`else
         exp_ch = (i >= 3);
`endif
         check($sformatf("order_%0d", i), 32'((i < order.size()) ? order[i] : 1'bx), 32'(exp_ch));
      end
      repeat (12) tick();

      // transmitter never drops ready
      tx_stuck = 1; chk_b2b = 1;
      do_reset();
      q_d.push_back(7'($urandom));
      q_p.push_back(7'($urandom));
      drive_inputs();
      wait_starts(2, 60, "tmo_starts");
      repeat (25) tick();
      check("tmo_count", 32'(n_tmo), 32'(2));
      tx_stuck = 0; chk_b2b = 0;
      tx_rdy_m = 1'b1;
      repeat (3) tick();

      // reset while waiting for ready high with both channels full
      tx_busy = 1;
      do_reset();
      q_d.push_back(7'h01); q_d.push_back(7'h02); q_p.push_back(7'h03);
      drive_inputs();
      repeat (3) tick();
      tx_busy = 0;
      drive_inputs();
      wait_starts(1, 10, "wh_first_start");
      for (int i = 0; i < 20 && tx_phase != 2; i++) tick();
      tx_busy = 1;
      drive_inputs();
      tick();
      tick();
      check("wh_both_full", 32'(m_df & m_pf), 32'(1));
      q_d.delete(); q_p.delete();
      i_reset = 1'b0;
      drive_inputs();
      tick();
      check("wh_rst_dat",   32'(o_uart_dat),   32'(8'h00));
      check("wh_rst_grant", 32'(o_grant),      32'(1));
      check("wh_rst_start", 32'(o_uart_start), 32'(0));
      tick();
      i_reset = 1'b1; tx_busy = 0; tx_phase = 0; tx_rdy_m = 1'b1;
      drive_inputs();
      n0 = n_start;
      repeat (20) tick();
      check("wh_no_start", 32'(n_start), 32'(n0));
      q_d.push_back(7'h55);
      drive_inputs();
      wait_starts(n0 + 1, 10, "wh_new_start");
      check("wh_new_dat", 32'(o_uart_dat), 32'(8'h55));
      repeat (12) tick();

      // random traffic
      do_reset();
      use_q = 0; rand_pct = 35;
      repeat (1500) tick();
      rand_pct = 0;
      repeat (100) tick();
      check("drain_data", 32'(m_df), 32'(0));
      check("drain_prot", 32'(m_pf), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TAG_PROT, default 1'b1: value placed in o_uart_dat[7] for protocol-channel bytes; data-channel bytes carry ~TAG_PROT.
REQ-002 SHALL have parameter READY_TIMEOUT, default 16: maximum cycles to wait for i_uart_ready to fall after a start; range 2..255.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_data_dat, input, 7: data-channel payload byte (bits 6:0).
REQ-006 SHALL have port i_data_valid, input, 1: data-channel byte offered.
REQ-007 SHALL have port o_data_ready, output, 1: data-channel holding register empty.
REQ-008 SHALL have port i_prot_dat, input, 7: protocol-channel payload byte.
REQ-009 SHALL have port i_prot_valid, input, 1: protocol-channel byte offered.
REQ-010 SHALL have port o_prot_ready, output, 1: protocol-channel holding register empty.
REQ-011 SHALL have port o_uart_dat, output, 8: {tag, payload} to the transmitter.
REQ-012 SHALL have port o_uart_start, output, 1: one-cycle start pulse to the transmitter.
REQ-013 SHALL have port i_uart_ready, input, 1: transmitter idle.
REQ-014 SHALL have port o_grant, output, 1: channel of last start (0 data, 1 protocol).
REQ-015 SHALL have port o_timeout, output, 1: one-cycle pulse on READY_TIMEOUT expiry.

Function
REQ-016 Each channel SHALL own a one-entry holding register plus full flag; o_x_ready = ~full_x.
REQ-017 valid && ready at an edge SHALL capture the payload and set full on that edge; valid without ready SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, START, WAIT_LOW, WAIT_HIGH.
REQ-019 IDLE: if any full flag set and i_uart_ready=1, SHALL select a channel, latch o_uart_dat, o_grant and go to START; otherwise stay.
REQ-020 START: o_uart_start=1 for exactly this cycle; the selected channel's full flag SHALL clear on the exiting edge; next state WAIT_LOW.
REQ-021 WAIT_LOW: on i_uart_ready=0 go to WAIT_HIGH; on READY_TIMEOUT cycles elapsed without it, pulse o_timeout and go to IDLE.
REQ-022 WAIT_HIGH: on i_uart_ready=1 go to IDLE.
REQ-023 Latency: byte captured at edge k with FSM idle and transmitter ready SHALL produce o_uart_start high in cycle k+2.
REQ-024 o_uart_dat and o_grant SHALL remain stable from START until the next START.
REQ-025 A channel freed in START MAY accept a new byte on the following edge; capture and clear SHALL never coincide on one channel.
REQ-026 Selection with one channel full SHALL pick that channel regardless of mode.
REQ-027 Timeout counter SHALL be 8 bits, cleared on entry to WAIT_LOW, saturating, not wrapping.

Reset
REQ-028 i_reset=0 at an edge SHALL force state IDLE, both full flags 0, o_uart_dat 8'h00, o_uart_start 0, o_grant 1, o_timeout 0, counter 0.
REQ-029 Reset during START/WAIT_LOW/WAIT_HIGH SHALL discard held bytes; no start pulse in the cycle after reset releases.
REQ-030 o_data_ready and o_prot_ready SHALL read 1 in the first cycle after reset releases.

Configuration
REQ-031 Macro UART_TX_ARB_RR_EN defined: with both channels full, the channel not equal to o_grant SHALL win (round-robin).
REQ-032 Macro UART_TX_ARB_RR_EN undefined: with both channels full, the data channel SHALL always win (fixed priority).

Verification
REQ-033 Data byte 7'h41 pushed, i_uart_ready=1 -> o_uart_start two cycles later, o_uart_dat=8'h41, o_grant=0.
REQ-034 Protocol byte 7'h12 pushed -> o_uart_dat=8'h92, o_grant=1.
REQ-035 Both channels full, three bytes each, transmitter model ready drop/rise -> RR order D,P,D,P,D,P; fixed order D,D,D,P,P,P.
REQ-036 Transmitter holds i_uart_ready=1 after start -> o_timeout pulses 16 cycles after WAIT_LOW entry, FSM back to IDLE, next byte starts.
REQ-037 Reset asserted in WAIT_HIGH with both channels full -> outputs at reset values, no start afterwards until a new push.
